// File: rtl/pa_fpu_frbus_wb.sv
// FPU write-back stage: arbitrates EX2 and FDSU results into a 2-entry in-order
// queue that drives the float register-file write port, and keeps sticky fflags.
module pa_fpu_frbus_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = 5,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  ctrl_frbus_ex2_wb_req,
  input  logic [DATA_WIDTH-1:0] dp_frbus_ex2_data,
  input  logic [FLAG_WIDTH-1:0] dp_frbus_ex2_fflags,
  input  logic [RD_WIDTH-1:0]   ctrl_frbus_ex2_rd,
  output logic                  frbus_ctrl_ex2_stall,
  input  logic                  fdsu_frbus_wb_vld,
  input  logic [DATA_WIDTH-1:0] fdsu_frbus_data,
  input  logic [FLAG_WIDTH-1:0] fdsu_frbus_fflags,
  input  logic [RD_WIDTH-1:0]   fdsu_frbus_rd,
  output logic                  frbus_fdsu_wb_grant,
  output logic                  frbus_rf_wb_vld,
  output logic [DATA_WIDTH-1:0] frbus_rf_wb_data,
  output logic [RD_WIDTH-1:0]   frbus_rf_wb_rd,
  input  logic                  rf_frbus_wb_ready,
  input  logic                  cp0_fpu_fflags_we,
  input  logic [FLAG_WIDTH-1:0] cp0_fpu_fflags_wdata,
  output logic [FLAG_WIDTH-1:0] fpu_cp0_fflags,
  output logic                  frbus_xx_idle
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [FLAG_WIDTH-1:0] fflags;
    logic [RD_WIDTH-1:0]   rd;
  } entry_t;

  entry_t                queue_q [2];
  logic                  wptr_q;
  logic                  rptr_q;
  logic [1:0]            count_q;
  logic [1:0]            fdsu_wait_q;
  logic [FLAG_WIDTH-1:0] fflags_q;

  logic   slot_free;
  logic   fdsu_prio;
  logic   ex2_accept;
  logic   fdsu_accept;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head;

  // Slot availability uses the registered count only, so a same-cycle pop
  // never makes room for a push (no bypass path).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    slot_free   = (count_q != 2'd2);
    fdsu_prio   = (fdsu_wait_q == 2'd3);
    ex2_accept  = slot_free && ctrl_frbus_ex2_wb_req && !(fdsu_frbus_wb_vld && fdsu_prio);
    fdsu_accept = slot_free && fdsu_frbus_wb_vld && (!ctrl_frbus_ex2_wb_req || fdsu_prio);
    push        = ex2_accept || fdsu_accept;
    push_entry  = '{data: fdsu_frbus_data, fflags: fdsu_frbus_fflags, rd: fdsu_frbus_rd};
    if (ex2_accept) begin
      push_entry = '{data: dp_frbus_ex2_data, fflags: dp_frbus_ex2_fflags, rd: ctrl_frbus_ex2_rd};
    end
  end

  assign head = queue_q[rptr_q];
  assign pop  = (count_q != 2'd0) && rf_frbus_wb_ready;

  // NOTE: the queue storage is reset too, so the head outputs read 0 out of reset.
  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < 2; i++) queue_q[i] <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      count_q     <= 2'd0;
      fdsu_wait_q <= 2'd0;
      fflags_q    <= '0;
    end else begin
      if (push) begin
        queue_q[wptr_q] <= push_entry;
        wptr_q          <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};

      if (fdsu_accept)                                fdsu_wait_q <= 2'd0;
      else if (fdsu_frbus_wb_vld && !fdsu_prio)       fdsu_wait_q <= fdsu_wait_q + 2'd1;

      // A CP0 write replaces the accrued flags but still absorbs a retiring head.
      if (cp0_fpu_fflags_we) fflags_q <= cp0_fpu_fflags_wdata | (pop ? head.fflags : '0);
      else if (pop)          fflags_q <= fflags_q | head.fflags;
    end
  end

  assign frbus_ctrl_ex2_stall = ctrl_frbus_ex2_wb_req && !ex2_accept;
  assign frbus_fdsu_wb_grant  = fdsu_accept;
  assign frbus_rf_wb_vld      = (count_q != 2'd0);
  assign frbus_rf_wb_data     = head.data;
  assign frbus_rf_wb_rd       = head.rd;
  assign fpu_cp0_fflags       = fflags_q;
  assign frbus_xx_idle        = (count_q == 2'd0) && !ctrl_frbus_ex2_wb_req && !fdsu_frbus_wb_vld;

endmodule

// File: tb/tb_pa_fpu_frbus_wb.sv
// Self-checking bench for pa_fpu_frbus_wb: vector table, directed corner
// sequences, and a scoreboard that checks retire order, data, rd and fflags.
module tb_pa_fpu_frbus_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex2_req;
  logic [31:0] ex2_data;
  logic [4:0]  ex2_fflags;
  logic [4:0]  ex2_rd;
  logic        ex2_stall;
  logic        fdsu_vld;
  logic [31:0] fdsu_data;
  logic [4:0]  fdsu_fflags;
  logic [4:0]  fdsu_rd;
  logic        fdsu_grant;
  logic        wb_vld;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_ready;
  logic        cp0_we;
  logic [4:0]  cp0_wdata;
  logic [4:0]  fflags;
  logic        idle;

  always #5 clk = ~clk;

  pa_fpu_frbus_wb dut (
    .forever_cpuclk        (clk),
    .cpurst_b              (rst_n),
    .ctrl_frbus_ex2_wb_req (ex2_req),
    .dp_frbus_ex2_data     (ex2_data),
    .dp_frbus_ex2_fflags   (ex2_fflags),
    .ctrl_frbus_ex2_rd     (ex2_rd),
    .frbus_ctrl_ex2_stall  (ex2_stall),
    .fdsu_frbus_wb_vld     (fdsu_vld),
    .fdsu_frbus_data       (fdsu_data),
    .fdsu_frbus_fflags     (fdsu_fflags),
    .fdsu_frbus_rd         (fdsu_rd),
    .frbus_fdsu_wb_grant   (fdsu_grant),
    .frbus_rf_wb_vld       (wb_vld),
    .frbus_rf_wb_data      (wb_data),
    .frbus_rf_wb_rd        (wb_rd),
    .rf_frbus_wb_ready     (wb_ready),
    .cp0_fpu_fflags_we     (cp0_we),
    .cp0_fpu_fflags_wdata  (cp0_wdata),
    .fpu_cp0_fflags        (fflags),
    .frbus_xx_idle         (idle)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  fflags;
    logic [4:0]  rd;
  } item_t;

  typedef struct {
    logic        src_fdsu;
    logic [31:0] data;
    logic [4:0]  fflags;
    logic [4:0]  rd;
    logic [4:0]  exp_fflags;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  item_t sb [$];
  logic [4:0] exp_ff = 5'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: retires are compared against accepted items in order, and the
  // accrued-flags model is advanced from the same observed handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_ff <= 5'b0;
    end else begin
      check("fflags_model", {27'b0, fflags}, {27'b0, exp_ff});
      if (wb_vld && wb_ready) begin
        if (sb.size() == 0) begin
          check("retire_unexpected", 32'd1, 32'd0);
          exp_ff <= cp0_we ? cp0_wdata : exp_ff;
        end else begin
          check("retire_data", wb_data, sb[0].data);
          check("retire_rd", {27'b0, wb_rd}, {27'b0, sb[0].rd});
          exp_ff <= (cp0_we ? cp0_wdata : exp_ff) | sb[0].fflags;
          sb.delete(0);
        end
      end else if (cp0_we) begin
        exp_ff <= cp0_wdata;
      end
      if (ex2_req && !ex2_stall) sb.push_back('{data: ex2_data, fflags: ex2_fflags, rd: ex2_rd});
      if (fdsu_vld && fdsu_grant) sb.push_back('{data: fdsu_data, fflags: fdsu_fflags, rd: fdsu_rd});
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!wb_vld) break;
      tick();
    end
    check({name, "_drained"}, {31'b0, wb_vld}, 32'd0);
    check({name, "_sb_empty"}, sb.size(), 32'd0);
    tick();
  endtask

  vec_t vecs [5];
  int   ex2_idx;
  int   fd_idx;
  logic exp_g;

  initial begin
    vecs[0] = '{1'b0, 32'h3F80_0000, 5'b00001, 5'd3,  5'b00001};
    vecs[1] = '{1'b1, 32'h4049_0FDB, 5'b00100, 5'd31, 5'b00101};
    vecs[2] = '{1'b0, 32'h7F80_0000, 5'b01000, 5'd8,  5'b01101};
    vecs[3] = '{1'b1, 32'h0000_0000, 5'b00000, 5'd0,  5'b01101};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 5'b10010, 5'd17, 5'b11111};

    rst_n = 1'b0; ex2_req = 1'b0; ex2_data = '0; ex2_fflags = '0; ex2_rd = '0;
    fdsu_vld = 1'b0; fdsu_data = '0; fdsu_fflags = '0; fdsu_rd = '0;
    wb_ready = 1'b1; cp0_we = 1'b0; cp0_wdata = '0;
    #12;
    check("reset_vld", {31'b0, wb_vld}, 32'd0);
    check("reset_fflags", {27'b0, fflags}, 32'd0);
    check("reset_idle", {31'b0, idle}, 32'd1);
    check("reset_data", wb_data, 32'd0);
    check("reset_rd", {27'b0, wb_rd}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single results from each producer, one-cycle latency, flags accrue.
    foreach (vecs[v]) begin
      if (vecs[v].src_fdsu) begin
        fdsu_vld = 1'b1; fdsu_data = vecs[v].data; fdsu_fflags = vecs[v].fflags; fdsu_rd = vecs[v].rd;
      end else begin
        ex2_req = 1'b1; ex2_data = vecs[v].data; ex2_fflags = vecs[v].fflags; ex2_rd = vecs[v].rd;
      end
      @(negedge clk);
      check("vec_stall", {31'b0, ex2_stall}, 32'd0);
      check("vec_grant", {31'b0, fdsu_grant}, {31'b0, vecs[v].src_fdsu});
      tick();
      ex2_req = 1'b0; fdsu_vld = 1'b0;
      @(negedge clk);
      check("vec_vld", {31'b0, wb_vld}, 32'd1);
      check("vec_data", wb_data, vecs[v].data);
      check("vec_rd", {27'b0, wb_rd}, {27'b0, vecs[v].rd});
      tick();
      @(negedge clk);
      check("vec_fflags", {27'b0, fflags}, {27'b0, vecs[v].exp_fflags});
      check("vec_idle", {31'b0, idle}, 32'd1);
      tick();
    end

    // Back-pressure: two fill the queue, third stalls until after a pop.
    wb_ready = 1'b0; ex2_fflags = 5'b0;
    ex2_req = 1'b1; ex2_data = 32'h1111_1111; ex2_rd = 5'd1;
    @(negedge clk); check("bp_stall1", {31'b0, ex2_stall}, 32'd0); tick();
    ex2_data = 32'h2222_2222; ex2_rd = 5'd2;
    @(negedge clk); check("bp_stall2", {31'b0, ex2_stall}, 32'd0); tick();
    ex2_data = 32'h3333_3333; ex2_rd = 5'd3;
    @(negedge clk); check("bp_stall3_full", {31'b0, ex2_stall}, 32'd1); tick();
    @(negedge clk); check("bp_stall3_hold", {31'b0, ex2_stall}, 32'd1); tick();
    wb_ready = 1'b1;
    @(negedge clk);
    check("bp_no_bypass", {31'b0, ex2_stall}, 32'd1);
    check("bp_head", wb_data, 32'h1111_1111);
    tick();
    @(negedge clk); check("bp_accept_after_pop", {31'b0, ex2_stall}, 32'd0); tick();
    ex2_req = 1'b0;
    drain("bp");

    // Starvation guard: FDSU wins on every 4th contested cycle, twice.
    ex2_idx = 0; fd_idx = 0;
    ex2_req = 1'b1; fdsu_vld = 1'b1; ex2_fflags = 5'b0; fdsu_fflags = 5'b0;
    for (int i = 0; i < 8; i++) begin
      exp_g = ((i % 4) == 3);
      ex2_data = 32'hA000_0000 + 32'(ex2_idx); ex2_rd = 5'(ex2_idx);
      fdsu_data = 32'hB000_0000 + 32'(fd_idx); fdsu_rd = 5'(fd_idx + 20);
      @(negedge clk);
      check("arb_grant", {31'b0, fdsu_grant}, {31'b0, exp_g});
      check("arb_stall", {31'b0, ex2_stall}, {31'b0, exp_g});
      if (exp_g) fd_idx++;
      else       ex2_idx++;
      tick();
    end
    ex2_req = 1'b0; fdsu_vld = 1'b0;
    drain("arb");

    // Retire and CP0 write in the same cycle merge.
    cp0_we = 1'b1; cp0_wdata = 5'b0; tick(); cp0_we = 1'b0;
    ex2_req = 1'b1; ex2_data = 32'hC0DE_0001; ex2_fflags = 5'b10000; ex2_rd = 5'd9;
    tick();
    ex2_req = 1'b0; cp0_we = 1'b1; cp0_wdata = 5'b00010;
    @(negedge clk); check("merge_retire_vld", {31'b0, wb_vld}, 32'd1);
    tick();
    cp0_we = 1'b0;
    @(negedge clk); check("merge_fflags", {27'b0, fflags}, 32'b10010);
    tick();

    // Reset with a full queue and all flags set.
    cp0_we = 1'b1; cp0_wdata = 5'b11111; tick(); cp0_we = 1'b0;
    wb_ready = 1'b0; ex2_fflags = 5'b0;
    ex2_req = 1'b1; ex2_data = 32'hDEAD_0001; ex2_rd = 5'd4; tick();
    ex2_data = 32'hDEAD_0002; ex2_rd = 5'd5; tick();
    ex2_req = 1'b0;
    @(negedge clk);
    check("pre_reset_full_fflags", {27'b0, fflags}, 32'b11111);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_vld", {31'b0, wb_vld}, 32'd0);
    check("rst_mid_fflags", {27'b0, fflags}, 32'd0);
    check("rst_mid_idle", {31'b0, idle}, 32'd1);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    wb_ready = 1'b1;
    ex2_req = 1'b1; ex2_data = 32'h0BAD_F00D; ex2_fflags = 5'b00001; ex2_rd = 5'd6;
    tick();
    ex2_req = 1'b0;
    @(negedge clk);
    check("post_rst_head", wb_data, 32'h0BAD_F00D);
    tick();
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
